// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Two-master Avalon-MM arbiter. It places the I-cache (m0) and D-cache (m1)
//   memory ports in front of one shared memory port. Requests pass through
//   combinationally with no added latency. The bus stays locked to the owning
//   master while it has reads outstanding, and read data returns to that owner.
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous, active-high reset
//   m0_avn_req   in   avalon_req_t   master 0 (I-cache) request
//   m0_avn_resp  out  avalon_resp_t  master 0 response
//   m1_avn_req   in   avalon_req_t   master 1 (D-cache) request
//   m1_avn_resp  out  avalon_resp_t  master 1 response
//   mem_avn_req  out  avalon_req_t   request to memory
//   mem_avn_resp in   avalon_resp_t  response from memory
//
// Build option
//   CACHE_ARB_RR_EN  defined   : round-robin on contention, using last_grant
//                    undefined : fixed priority, m0 always wins contention
//
// State   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | pending == 0; the winner is chosen combinationally and forwarded
// LOCKED  | pending != 0; only owner is forwarded; owner writes wait for drain

package cache_mem_arbiter_pkg;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
    } avalon_req_t;

    typedef struct packed {
        logic [31:0] readdata;
        logic        waitrequest;
        logic        readdatavalid;
    } avalon_resp_t;

endpackage

module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int MAX_PENDING = 2,
    parameter int PEND_W      = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  avalon_req_t  m0_avn_req,
    output avalon_resp_t m0_avn_resp,
    input  avalon_req_t  m1_avn_req,
    output avalon_resp_t m1_avn_resp,
    output avalon_req_t  mem_avn_req,
    input  avalon_resp_t mem_avn_resp
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [PEND_W-1:0] pending_q, pending_d;

    logic [0:0]        state;
    logic              m0_active, m1_active;
    logic              winner;
    logic              sel;
    avalon_req_t       sel_req;
    logic              sel_active;
    logic              gate;
    logic              forward;
    logic              accept;
    logic              accept_read;
    logic              rdv_valid;

    always_comb begin
        m0_active = m0_avn_req.read | m0_avn_req.write;
        m1_active = m1_avn_req.read | m1_avn_req.write;
        state     = (pending_q == '0) ? ST_IDLE : ST_LOCKED;

        // With nobody requesting, the winner defaults to m0 so the idle
        // address/data fields follow m0.
        winner = 1'b0;
        if (m0_active && m1_active) begin
`ifdef CACHE_ARB_RR_EN
            winner = ~last_grant_q;
`else
            winner = 1'b0;
`endif
        end else if (m1_active) begin
            winner = 1'b1;
        end

        sel        = (state == ST_IDLE) ? winner : owner_q;
        sel_req    = sel ? m1_avn_req : m0_avn_req;
        sel_active = sel_req.read | sel_req.write;

        // While locked, a write must wait for all reads to drain. A read waits
        // only when the outstanding window is full.
        gate = 1'b0;
        if (state == ST_LOCKED) begin
            gate = sel_req.write | (sel_req.read & (pending_q >= PEND_MAX));
        end

        forward = sel_active & ~gate & ~rst;

        mem_avn_req       = sel_req;
        mem_avn_req.read  = sel_req.read  & forward;
        mem_avn_req.write = sel_req.write & forward;

        accept      = forward & ~mem_avn_resp.waitrequest;
        accept_read = accept & sel_req.read;

        // A readdatavalid with no outstanding read is not passed on.
        rdv_valid = mem_avn_resp.readdatavalid & (state == ST_LOCKED) & ~rst;

        m0_avn_resp.readdata      = mem_avn_resp.readdata;
        m1_avn_resp.readdata      = mem_avn_resp.readdata;
        m0_avn_resp.readdatavalid = rdv_valid & ~owner_q;
        m1_avn_resp.readdatavalid = rdv_valid &  owner_q;

        m0_avn_resp.waitrequest = 1'b1;
        m1_avn_resp.waitrequest = 1'b1;
        if (sel_active && !rst) begin
            if (sel) begin
                m1_avn_resp.waitrequest = gate | mem_avn_resp.waitrequest;
            end else begin
                m0_avn_resp.waitrequest = gate | mem_avn_resp.waitrequest;
            end
        end

        // Ownership moves only when an IDLE request is actually accepted.
        // The winner therefore stays stable while memory holds waitrequest,
        // and round-robin cannot switch masters mid-transfer.
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        if ((state == ST_IDLE) && accept) begin
            owner_d      = sel;
            last_grant_d = sel;
        end

        pending_d = pending_q;
        case ({accept_read, rdv_valid})
            2'b10:   pending_d = pending_q + PEND_ONE;
            2'b01:   pending_d = pending_q - PEND_ONE;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            pending_q    <= '0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//   Self-checking bench for cache_mem_arbiter. It runs directed scenarios
//   first and then randomized traffic. Every cycle is compared against a
//   behavioural model of pending count, owner and last grant. The model
//   respects the CACHE_ARB_RR_EN build option.

module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam int MAXP = 2;
`ifdef CACHE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    avalon_req_t  m0_req, m1_req, mem_req;
    avalon_resp_t m0_resp, m1_resp, mem_resp;

    int n_checks = 0;
    int n_errors = 0;

    int mdl_pend, mdl_owner, mdl_last;
    int nxt_pend, nxt_owner, nxt_last;

    cache_mem_arbiter #(.MAX_PENDING(MAXP), .PEND_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_avn_req   (m0_req),
        .m0_avn_resp  (m0_resp),
        .m1_avn_req   (m1_req),
        .m1_avn_resp  (m1_resp),
        .mem_avn_req  (mem_req),
        .mem_avn_resp (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_m(input int m, input int op, input logic [31:0] addr);
        avalon_req_t r;
        r.read       = (op == 1);
        r.write      = (op == 2);
        r.address    = addr;
        r.writedata  = $urandom;
        r.byteenable = 4'($urandom);
        if (m == 0) m0_req = r;
        else        m1_req = r;
    endtask

    task automatic drive_mem(input logic wr, input logic rdv, input logic [31:0] data);
        mem_resp.waitrequest   = wr;
        mem_resp.readdatavalid = rdv;
        mem_resp.readdata      = data;
    endtask

    // Expected outputs follow from the arbitration rules applied to the model
    // state. This task also computes the model state for after the next edge.
    task automatic model_check();
        logic        r0, r1, act, gated, fwd, exp_w0, exp_w1, exp_rdv;
        int          sel;
        avalon_req_t s;
        if (rst) begin
            mdl_pend  = 0;
            mdl_owner = 0;
            mdl_last  = 1;
        end
        nxt_pend  = mdl_pend;
        nxt_owner = mdl_owner;
        nxt_last  = mdl_last;

        r0 = m0_req.read || m0_req.write;
        r1 = m1_req.read || m1_req.write;
        if (mdl_pend == 0) begin
            if (r0 && r1) sel = RR ? (1 - mdl_last) : 0;
            else          sel = r1 ? 1 : 0;
        end else begin
            sel = mdl_owner;
        end
        s     = (sel == 1) ? m1_req : m0_req;
        act   = s.read || s.write;
        gated = (mdl_pend != 0) && (s.write || (s.read && mdl_pend >= MAXP));
        fwd   = act && !gated && !rst;

        chk("mem_read",  32'(mem_req.read),  32'(fwd && s.read));
        chk("mem_write", 32'(mem_req.write), 32'(fwd && s.write));
        if (fwd) begin
            chk("mem_addr",  mem_req.address,   s.address);
            chk("mem_wdata", mem_req.writedata, s.writedata);
            chk("mem_be",    32'(mem_req.byteenable), 32'(s.byteenable));
        end else if (mdl_pend == 0 && !r0 && !r1 && !rst) begin
            chk("mem_addr_idle", mem_req.address, m0_req.address);
        end

        exp_w0 = 1'b1;
        exp_w1 = 1'b1;
        if (act && !rst) begin
            if (sel == 0) exp_w0 = gated || mem_resp.waitrequest;
            else          exp_w1 = gated || mem_resp.waitrequest;
        end
        chk("m0_wait", 32'(m0_resp.waitrequest), 32'(exp_w0));
        chk("m1_wait", 32'(m1_resp.waitrequest), 32'(exp_w1));

        exp_rdv = mem_resp.readdatavalid && (mdl_pend != 0) && !rst;
        chk("m0_rdv", 32'(m0_resp.readdatavalid), 32'(exp_rdv && mdl_owner == 0));
        chk("m1_rdv", 32'(m1_resp.readdatavalid), 32'(exp_rdv && mdl_owner == 1));
        chk("m0_rdata", m0_resp.readdata, mem_resp.readdata);
        chk("m1_rdata", m1_resp.readdata, mem_resp.readdata);
        chk("pending", 32'(dut.pending_q), 32'(mdl_pend));

        if (fwd && !mem_resp.waitrequest) begin
            if (mdl_pend == 0) begin
                nxt_owner = sel;
                nxt_last  = sel;
            end
            if (s.read) nxt_pend = nxt_pend + 1;
        end
        if (exp_rdv) nxt_pend = nxt_pend - 1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic finish_cycle();
        model_check();
        @(posedge clk);
        if (rst) begin
            mdl_pend  = 0;
            mdl_owner = 0;
            mdl_last  = 1;
        end else begin
            mdl_pend  = nxt_pend;
            mdl_owner = nxt_owner;
            mdl_last  = nxt_last;
        end
        #1;
    endtask

    task automatic cycle();
        settle();
        finish_cycle();
    endtask

    initial begin
        logic [31:0] exp_addr;
        mdl_pend  = 0;
        mdl_owner = 0;
        mdl_last  = 1;
        rst = 1'b1;
        drive_m(0, 1, 32'h10);
        drive_m(1, 1, 32'h20);
        drive_mem(1'b0, 1'b1, 32'h0);

        // reset with both masters reading
        settle();
        chk("rst_mem_read", 32'(mem_req.read), 32'd0);
        chk("rst_m0_wait",  32'(m0_resp.waitrequest), 32'd1);
        chk("rst_m1_wait",  32'(m1_resp.waitrequest), 32'd1);
        chk("rst_m0_rdv",   32'(m0_resp.readdatavalid), 32'd0);
        chk("rst_m1_rdv",   32'(m1_resp.readdatavalid), 32'd0);
        finish_cycle();
        cycle();
        rst = 1'b0;

        // single read from m1, data two cycles later
        drive_m(0, 0, 32'h0);
        drive_m(1, 1, 32'h100);
        drive_mem(1'b0, 1'b0, 32'h0);
        settle();
        chk("sr_mem_read", 32'(mem_req.read), 32'd1);
        chk("sr_mem_addr", mem_req.address, 32'h100);
        chk("sr_m1_wait",  32'(m1_resp.waitrequest), 32'd0);
        finish_cycle();
        chk("sr_pend1", 32'(dut.pending_q), 32'd1);
        drive_m(1, 0, 32'h0);
        cycle();
        drive_mem(1'b0, 1'b1, 32'hDEADBEEF);
        settle();
        chk("sr_m1_rdv",   32'(m1_resp.readdatavalid), 32'd1);
        chk("sr_m1_rdata", m1_resp.readdata, 32'hDEADBEEF);
        chk("sr_m0_rdv",   32'(m0_resp.readdatavalid), 32'd0);
        finish_cycle();
        chk("sr_pend0", 32'(dut.pending_q), 32'd0);
        drive_mem(1'b0, 1'b0, 32'h0);

        // contention: both masters write continuously (last grant was m1)
        drive_m(0, 2, 32'hA0);
        drive_m(1, 2, 32'hB0);
        for (int i = 0; i < 4; i++) begin
            settle();
            exp_addr = (RR && (i % 2 == 1)) ? 32'hB0 : 32'hA0;
            chk("cont_write", 32'(mem_req.write), 32'd1);
            chk("cont_grant", mem_req.address, exp_addr);
            finish_cycle();
        end

        // lock: m0 issues three reads while m1 waits to write
        drive_m(0, 1, 32'h40);
        drive_m(1, 2, 32'hB4);
        cycle();
        cycle();
        settle();
        chk("lock_3rd_wait",  32'(m0_resp.waitrequest), 32'd1);
        chk("lock_mem_read",  32'(mem_req.read), 32'd0);
        chk("lock_m1_wait",   32'(m1_resp.waitrequest), 32'd1);
        finish_cycle();
        drive_m(0, 0, 32'h0);
        drive_mem(1'b0, 1'b1, 32'h1111);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("lock_drain_m1_wait", 32'(m1_resp.waitrequest), 32'd1);
            chk("lock_drain_mem_wr",  32'(mem_req.write), 32'd0);
            finish_cycle();
        end
        drive_mem(1'b0, 1'b0, 32'h0);
        settle();
        chk("lock_m1_grant", 32'(mem_req.write), 32'd1);
        chk("lock_m1_addr",  mem_req.address, 32'hB4);
        chk("lock_m1_wait",  32'(m1_resp.waitrequest), 32'd0);
        finish_cycle();
        drive_m(1, 0, 32'h0);

        // read accepted in the same cycle as readdatavalid
        drive_m(0, 1, 32'h50);
        cycle();
        drive_mem(1'b0, 1'b1, 32'h2222);
        cycle();
        chk("sim_pend", 32'(dut.pending_q), 32'd1);
        drive_m(0, 0, 32'h0);
        drive_m(1, 2, 32'hB8);
        drive_mem(1'b0, 1'b0, 32'h0);
        settle();
        chk("sim_locked_wr",   32'(mem_req.write), 32'd0);
        chk("sim_locked_wait", 32'(m1_resp.waitrequest), 32'd1);
        finish_cycle();
        drive_mem(1'b0, 1'b1, 32'h3333);
        cycle();
        drive_mem(1'b0, 1'b0, 32'h0);
        settle();
        chk("sim_m1_grant", 32'(mem_req.write), 32'd1);
        finish_cycle();
        drive_m(1, 0, 32'h0);

        // spurious readdatavalid while idle
        drive_mem(1'b0, 1'b1, 32'h4444);
        settle();
        chk("spur_m0_rdv", 32'(m0_resp.readdatavalid), 32'd0);
        chk("spur_m1_rdv", 32'(m1_resp.readdatavalid), 32'd0);
        finish_cycle();
        chk("spur_pend", 32'(dut.pending_q), 32'd0);
        drive_mem(1'b0, 1'b0, 32'h0);

        // reset with two reads outstanding
        drive_m(0, 1, 32'h60);
        cycle();
        cycle();
        chk("rmid_pend2", 32'(dut.pending_q), 32'd2);
        drive_m(0, 0, 32'h0);
        rst = 1'b1;
        settle();
        chk("rmid_pend0", 32'(dut.pending_q), 32'd0);
        finish_cycle();
        rst = 1'b0;
        drive_m(1, 2, 32'hBC);
        drive_mem(1'b0, 1'b1, 32'h5555);
        settle();
        chk("rmid_m1_grant", 32'(mem_req.write), 32'd1);
        chk("rmid_m1_addr",  mem_req.address, 32'hBC);
        chk("rmid_m1_wait",  32'(m1_resp.waitrequest), 32'd0);
        chk("rmid_m0_rdv",   32'(m0_resp.readdatavalid), 32'd0);
        chk("rmid_m1_rdv",   32'(m1_resp.readdatavalid), 32'd0);
        finish_cycle();
        drive_m(1, 0, 32'h0);
        drive_mem(1'b0, 1'b0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive_m(0, int'($urandom_range(0, 3)), $urandom);
            drive_m(1, int'($urandom_range(0, 3)), $urandom);
            if (mdl_pend != 0)
                drive_mem($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom);
            else
                drive_mem($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
